hilo_mac: RTL and testbench
===========================

Name: hilo_mac

Overview:
- Execute-stage controller sitting directly upstream and downstream of the 2-cycle Booth/Wallace multiplier `mul`.
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL from the decoder, drives `mul`'s START/CANCEL/operand inputs, and consumes its 64-bit RESULT/READY.
- Owns the architectural HI/LO registers and performs the MADD/MSUB accumulate.
- Stalls the pipeline while a multiply is in flight and honours flushes.

Parameters:
- DATA_W, 32, GPR/HI/LO width; product width is 2*DATA_W.

Ports:
- CLK  in  1  clock. One clock domain; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- OP_VALID  in  1  decoder presents a multiply op this cycle.
- OP  in  3  000 none, 001 MULT, 010 MULTU, 011 MADD, 100 MADDU, 101 MSUB, 110 MSUBU, 111 MUL (GPR destination).
- SRC_A  in  32  rs operand.
- SRC_B  in  32  rt operand.
- FLUSH  in  1  kill in-flight op.
- MTHI_EN  in  1  write WDATA to HI.
- MTLO_EN  in  1  write WDATA to LO.
- WDATA  in  32  MTHI/MTLO data.
- MUL_START  out  1  to mul START.
- MUL_CANCEL  out  1  to mul CANCEL.
- MUL_SIGNED  out  1  to mul SIGNED_MUL.
- MUL_A  out  32  to mul MULTIPLIER.
- MUL_B  out  32  to mul MULTIPLICAND.
- MUL_RESULT  in  64  from mul RESULT.
- MUL_READY  in  1  from mul READY.
- STALL_REQ  out  1  hold pipeline.
- GPR_RESULT  out  32  MUL low word.
- GPR_VALID  out  1  GPR_RESULT valid.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset: state IDLE; HI=LO=0; latched op/operands=0; all outputs 0. Reset mid-operation discards the op; no HI/LO write.
- States: IDLE, ISSUE, WAIT, ACC.
- IDLE:
  - Accept when OP_VALID & OP!=0 & !FLUSH. Latch OP, SRC_A, SRC_B; go to ISSUE. STALL_REQ=1 combinationally in the accept cycle.
  - MTHI_EN/MTLO_EN write HI/LO at the edge, only when not accepting. When accepting, the op wins and MT* is ignored.
  - MT* in any other state is ignored.
- ISSUE: MUL_START=1 for exactly one cycle; go to WAIT. STALL_REQ=1.
- MUL_A/MUL_B: driven from latched SRC_A/SRC_B; stable from ISSUE until the next accept.
- MUL_SIGNED: 1 for MULT/MADD/MSUB/MUL, 0 otherwise.
- WAIT:
  - Stay while !MUL_READY (STALL_REQ=1).
  - On MUL_READY with MULT/MULTU: {HI,LO}<=MUL_RESULT at the edge; STALL_REQ=0 this cycle; go to IDLE.
  - On MUL_READY with MUL: GPR_VALID=1 and GPR_RESULT=MUL_RESULT[31:0] combinationally this cycle; HI/LO unchanged; STALL_REQ=0; go to IDLE.
  - On MUL_READY with MADD*/MSUB*: latch MUL_RESULT into product register; STALL_REQ=1; go to ACC.
- ACC:
  - MADD/MADDU: {HI,LO}<={HI,LO}+product. MSUB/MSUBU: {HI,LO}<={HI,LO}-product. Both are 64-bit modulo, no overflow trap.
  - STALL_REQ=0; go to IDLE.
- GPR_RESULT=0 whenever GPR_VALID=0.
- Latency, counting the accept cycle as 0:
  - MULT/MUL: stall high cycles 0-1, completion cycle 2; HI/LO visible cycle 3.
  - MADD/MSUB: stall high 0-2, completion cycle 3; visible cycle 4.
- FLUSH:
  - In ISSUE/WAIT/ACC: MUL_CANCEL=1 that cycle, MUL_START=0, STALL_REQ=0. No HI/LO write, no GPR_VALID. Next state IDLE.
  - In IDLE: suppresses accept and MT* writes.
- A READY arriving in IDLE or ISSUE is ignored.

Test Plan:
- MULT 0xFFFFFFFF × 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at cycle 3; STALL_REQ high cycles 0-1 only; MUL_START one pulse in cycle 1.
- MULTU 0xFFFFFFFF × 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; MUL_SIGNED=0.
- MTHI 0, MTLO 0x10, then MADDU 3×5 -> HI=0, LO=0x1F at cycle 4. Then MSUB 0x20×1 -> HI=LO=0xFFFFFFFF.
- MUL 0x00010001 × 0x00010000 -> GPR_VALID single pulse in cycle 2 with GPR_RESULT=0x00010000; HI/LO unchanged.
- MADD with FLUSH asserted in WAIT -> MUL_CANCEL pulse, STALL_REQ low that cycle, HI/LO unchanged. A MULT presented the next cycle is accepted and completes normally.
- RST asserted in ACC with HI=LO=0x5 -> next cycle IDLE, HI=LO=0, STALL_REQ=0. Also: MTHI_EN together with an accepted MULT -> MTHI ignored.

Source files
------------

// File: rtl/hilo_mac_if.sv
// Bundle of decoder, multiplier and HI/LO-visible signals around the hilo_mac controller.
interface hilo_mac_if #(
  parameter int unsigned DATA_W = 32
);
  // Decoder side
  logic                  op_valid;
  logic [2:0]            op;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic                  flush;
  logic                  mthi_en;
  logic                  mtlo_en;
  logic [DATA_W-1:0]     wdata;
  // Multiplier side
  logic                  mul_start;
  logic                  mul_cancel;
  logic                  mul_signed;
  logic [DATA_W-1:0]     mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic [2*DATA_W-1:0]   mul_result;
  logic                  mul_ready;
  // Pipeline / architectural state
  logic                  stall_req;
  logic [DATA_W-1:0]     gpr_result;
  logic                  gpr_valid;
  logic [DATA_W-1:0]     hi;
  logic [DATA_W-1:0]     lo;

  modport slave (
    input  op_valid, op, src_a, src_b, flush, mthi_en, mtlo_en, wdata,
    input  mul_result, mul_ready,
    output mul_start, mul_cancel, mul_signed, mul_a, mul_b,
    output stall_req, gpr_result, gpr_valid, hi, lo
  );

  modport master (
    output op_valid, op, src_a, src_b, flush, mthi_en, mtlo_en, wdata,
    output mul_result, mul_ready,
    input  mul_start, mul_cancel, mul_signed, mul_a, mul_b,
    input  stall_req, gpr_result, gpr_valid, hi, lo
  );
endinterface

// File: rtl/hilo_mac.sv
// Execute-stage multiply controller: issues ops to the external multiplier, owns HI/LO,
// performs MADD/MSUB accumulation and stalls the pipeline while an op is in flight.
module hilo_mac #(
  parameter int unsigned DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_mac_if.slave bus
);

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpMadd  = 3'b011;
  localparam logic [2:0] OpMaddu = 3'b100;
  localparam logic [2:0] OpMsub  = 3'b101;
  localparam logic [2:0] OpMsubu = 3'b110;
  localparam logic [2:0] OpMul   = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAcc} state_e;

  state_e                state_q;
  logic [2:0]            op_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic [2*DATA_W-1:0]   prod_q;

  logic                  accept;
  logic                  is_acc_op;
  logic                  is_add_op;
  logic                  stall;
  logic                  start;
  logic                  cancel;
  logic                  gpr_valid;
  logic [2*DATA_W-1:0]   hilo_sum;
  logic [2*DATA_W-1:0]   hilo_diff;

  // Decode accept, handshake outputs and accumulate results from the current state.
  always_comb begin
    accept    = (state_q == StIdle) && bus.op_valid && (bus.op != OpNone) && !bus.flush;
    is_acc_op = (op_q == OpMadd) || (op_q == OpMaddu) || (op_q == OpMsub) || (op_q == OpMsubu);
    is_add_op = (op_q == OpMadd) || (op_q == OpMaddu);
    hilo_sum  = {hi_q, lo_q} + prod_q;
    hilo_diff = {hi_q, lo_q} - prod_q;
    stall     = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    gpr_valid = 1'b0;
    unique case (state_q)
      StIdle:  stall = accept;
      StIssue: begin
        cancel = bus.flush;
        start  = !bus.flush;
        stall  = !bus.flush;
      end
      StWait: begin
        cancel    = bus.flush;
        // Accumulating ops keep the pipe held for the extra ACC cycle.
        stall     = !bus.flush && (!bus.mul_ready || is_acc_op);
        gpr_valid = !bus.flush && bus.mul_ready && (op_q == OpMul);
      end
      StAcc:   cancel = bus.flush;
      default: ;
    endcase
  end

  assign bus.stall_req  = stall;
  assign bus.mul_start  = start;
  assign bus.mul_cancel = cancel;
  assign bus.gpr_valid  = gpr_valid;
  assign bus.gpr_result = gpr_valid ? bus.mul_result[DATA_W-1:0] : '0;
  assign bus.mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub) ||
                          (op_q == OpMul);
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  // FSM plus HI/LO, latched op/operands and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= bus.op;
            a_q     <= bus.src_a;
            b_q     <= bus.src_b;
            state_q <= StIssue;
          end else if (!bus.flush) begin
            if (bus.mthi_en) hi_q <= bus.wdata;
            if (bus.mtlo_en) lo_q <= bus.wdata;
          end
        end
        StIssue: state_q <= bus.flush ? StIdle : StWait;
        StWait: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else if (bus.mul_ready) begin
            if (is_acc_op) begin
              prod_q  <= bus.mul_result;
              state_q <= StAcc;
            end else begin
              if (op_q != OpMul) {hi_q, lo_q} <= bus.mul_result;
              state_q <= StIdle;
            end
          end
        end
        StAcc: begin
          state_q <= StIdle;
          if (!bus.flush) {hi_q, lo_q} <= is_add_op ? hilo_sum : hilo_diff;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mac.sv
// Self-checking bench for hilo_mac with a behavioural multiplier and a result scoreboard.
module tb_hilo_mac;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          extra;
    logic        mt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_gv;
    logic [31:0] exp_gpr;
    logic        exp_sgn;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   mul_extra;
  int   mul_cnt;
  logic [63:0] mul_res;
  vec_t vecs[10];
  vec_t sb_q[$];

  hilo_mac_if #(.DATA_W(32)) bus ();

  hilo_mac #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: READY one cycle after START plus mul_extra cycles.
  always @(posedge clk) begin
    if (rst || bus.mul_cancel) begin
      mul_cnt <= 0;
    end else if (bus.mul_start) begin
      mul_cnt <= mul_extra + 1;
      if (bus.mul_signed)
        mul_res <= $signed({{32{bus.mul_a[31]}}, bus.mul_a}) *
                   $signed({{32{bus.mul_b[31]}}, bus.mul_b});
      else
        mul_res <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
    end else if (mul_cnt != 0) begin
      mul_cnt <= mul_cnt - 1;
    end
  end
  assign bus.mul_ready  = (mul_cnt == 1);
  assign bus.mul_result = mul_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    bus.mthi_en = 1'b1; bus.wdata = h;
    @(posedge clk); #1;
    bus.mthi_en = 1'b0; bus.mtlo_en = 1'b1; bus.wdata = l;
    @(posedge clk); #1;
    bus.mtlo_en = 1'b0; bus.wdata = '0;
    @(negedge clk);
    check("mthi", {32'b0, bus.hi}, {32'b0, h});
    check("mtlo", {32'b0, bus.lo}, {32'b0, l});
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit do_pre);
    int   starts, start_cyc, stalls, gpulses, lat;
    logic [31:0] gseen;
    logic sgn;
    bit   done;
    vec_t e;
    if (do_pre) write_hilo(v.pre_hi, v.pre_lo);
    sb_q.push_back(v);
    starts = 0; start_cyc = -1; stalls = 0; gpulses = 0; lat = -1;
    gseen = '0; sgn = 1'bx; done = 1'b0;
    mul_extra = v.extra;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.op_valid = 1'b1; bus.op = v.op; bus.src_a = v.a; bus.src_b = v.b;
    if (v.mt) begin
      bus.mthi_en = 1'b1; bus.wdata = 32'hDEADBEEF;
    end
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (bus.mul_start) begin
        starts++; start_cyc = c; sgn = bus.mul_signed;
      end
      if (bus.gpr_valid) begin
        gpulses++; gseen = bus.gpr_result;
      end
      if (bus.stall_req) stalls++;
      else if (c > 0) begin
        done = 1'b1; lat = c;
      end
      @(posedge clk); #1;
      bus.op_valid = 1'b0; bus.op = '0; bus.mthi_en = 1'b0; bus.wdata = '0;
    end
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("v%0d done", idx), {63'b0, done}, 64'd1);
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(e.exp_lat));
    check($sformatf("v%0d stall cycles", idx), 64'(stalls), 64'(e.exp_lat));
    check($sformatf("v%0d start pulses", idx), 64'(starts), 64'd1);
    check($sformatf("v%0d start cycle", idx), 64'(start_cyc), 64'd1);
    check($sformatf("v%0d signed", idx), {63'b0, sgn}, {63'b0, e.exp_sgn});
    check($sformatf("v%0d gpr pulses", idx), 64'(gpulses), {63'b0, e.exp_gv});
    check($sformatf("v%0d gpr", idx), {32'b0, gseen}, {32'b0, e.exp_gpr});
    check($sformatf("v%0d gpr idle", idx), {32'b0, bus.gpr_result}, 64'd0);
    check($sformatf("v%0d hi", idx), {32'b0, bus.hi}, {32'b0, e.exp_hi});
    check($sformatf("v%0d lo", idx), {32'b0, bus.lo}, {32'b0, e.exp_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t fv;
    n_vec = 0; n_err = 0; mul_extra = 0;
    //              op     a             b             pre_hi        pre_lo     ext mt exp_hi        exp_lo      gv gpr            sg lat
    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 32'h0,        1, 2};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        0, 0, 32'h00000001, 32'hFFFFFFFE, 0, 32'h0,        0, 2};
    vecs[2] = '{3'd4, 32'h3,        32'h5,        32'h0,        32'h10,       0, 0, 32'h0,        32'h1F,       0, 32'h0,        0, 3};
    vecs[3] = '{3'd5, 32'h20,       32'h1,        32'h0,        32'h1F,       0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        1, 3};
    vecs[4] = '{3'd7, 32'h00010001, 32'h00010000, 32'hAAAA,     32'h5555,     0, 0, 32'hAAAA,     32'h5555,     1, 32'h00010000, 1, 2};
    vecs[5] = '{3'd3, 32'hFFFFFFFF, 32'h3,        32'h0,        32'h2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        1, 3};
    vecs[6] = '{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000001, 32'hFFFFFFFE, 0, 32'h0,        0, 3};
    vecs[7] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        3, 0, 32'h3FFFFFFF, 32'h00000001, 0, 32'h0,        1, 5};
    vecs[8] = '{3'd3, 32'h1,        32'h1,        32'h0,        32'hFFFFFFFF, 0, 0, 32'h00000001, 32'h0,        0, 32'h0,        1, 3};
    vecs[9] = '{3'd1, 32'h2,        32'h3,        32'h1234,     32'h5678,     0, 1, 32'h0,        32'h6,        0, 32'h0,        1, 2};

    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset hi", {32'b0, bus.hi}, 64'd0);
    check("reset lo", {32'b0, bus.lo}, 64'd0);
    check("reset stall", {63'b0, bus.stall_req}, 64'd0);
    check("reset start", {63'b0, bus.mul_start}, 64'd0);
    check("reset cancel", {63'b0, bus.mul_cancel}, 64'd0);
    check("reset gpr_valid", {63'b0, bus.gpr_valid}, 64'd0);
    check("reset mul_a", {32'b0, bus.mul_a}, 64'd0);
    check("reset signed", {63'b0, bus.mul_signed}, 64'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i], 1'b1);

    // FLUSH in IDLE blocks both the accept and an MTHI write.
    write_hilo(32'h11, 32'h22);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'd1; bus.flush = 1'b1; bus.mthi_en = 1'b1; bus.wdata = 32'h99;
    @(negedge clk);
    check("idle flush stall", {63'b0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = '0; bus.flush = 1'b0; bus.mthi_en = 1'b0; bus.wdata = '0;
    @(negedge clk);
    check("idle flush start", {63'b0, bus.mul_start}, 64'd0);
    check("idle flush hi", {32'b0, bus.hi}, 64'h11);

    // FLUSH while a MADD waits on the multiplier, then a MULT next cycle.
    write_hilo(32'h77, 32'h77);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'd3; bus.src_a = 32'h2; bus.src_b = 32'h3;
    @(negedge clk);
    check("wflush accept stall", {63'b0, bus.stall_req}, 64'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = '0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("wflush cancel", {63'b0, bus.mul_cancel}, 64'd1);
    check("wflush stall", {63'b0, bus.stall_req}, 64'd0);
    check("wflush start", {63'b0, bus.mul_start}, 64'd0);
    check("wflush gpr_valid", {63'b0, bus.gpr_valid}, 64'd0);
    check("wflush hi", {32'b0, bus.hi}, 64'h77);
    fv = '{3'd1, 32'h4, 32'h5, 32'h0, 32'h0, 0, 0, 32'h0, 32'h14, 0, 32'h0, 1, 2};
    run_vec(10, fv, 1'b0);

    // RST during ACC discards the accumulate and clears state.
    write_hilo(32'h5, 32'h5);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'd3; bus.src_a = 32'h1; bus.src_b = 32'h1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("acc stall", {63'b0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst acc hi", {32'b0, bus.hi}, 64'd0);
    check("rst acc lo", {32'b0, bus.lo}, 64'd0);
    check("rst acc stall", {63'b0, bus.stall_req}, 64'd0);
    check("rst acc mul_a", {32'b0, bus.mul_a}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst acc hi later", {32'b0, bus.hi}, 64'd0);
    check("rst acc lo later", {32'b0, bus.lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
